// File: rtl/dark_pkg.sv
// Shared fetch-side types and constants.
// Holds the fetch FSM encoding and the instruction buffer entry layout.
package dark_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int FETCH_DEPTH = 2;
  localparam int INST_BYTES  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/dark_fetch_buf.sv
// Two-entry instruction buffer between fetch and decode.
// Ports: clk, res (sync active-low), push/push_ent, pop, flush, count, head.
module dark_fetch_buf
  import dark_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       push,
  input  fetch_ent_t push_ent,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output fetch_ent_t head
);

  fetch_ent_t mem [FETCH_DEPTH];
  logic       rd_ptr;
  logic       wr_ptr;

  always_ff @(posedge clk) begin
    if (!res) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (res && !flush && push)
      mem[wr_ptr] <= push_ent;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dark_fetch_ctl.sv
// Instruction fetch controller: issues imem requests, buffers responses
// and hands them to decode; ports: clk/res, imem_*, redir_*, inst_*, pc_*.
module dark_fetch_ctl
  import dark_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redir_v,
  input  logic [31:0] redir_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        pc_en,
  output logic [31:0] pc_nxpc
);

  fetch_state_t state;
  fetch_state_t state_nx;

  logic [31:0] fetch_pc;
  logic [31:0] hold_addr;
  logic [31:0] redir_tgt;
  logic [1:0]  count;
  fetch_ent_t  head;
  fetch_ent_t  push_ent;
  logic        issue;
  logic        active;
  logic        done;
  logic        hs;
  logic        push;
  logic        can_cont;

  assign redir_tgt  = redir_pc & ~32'h3;
  assign inst_valid = (count != 2'd0);
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign hs         = inst_valid & inst_ready;
  assign done       = imem_req & imem_ack;
  assign active     = (state == BUSY) | issue;
  assign push       = done & active & ~redir_v;
  assign push_ent   = '{pc: fetch_pc, inst: imem_data};

  // Post-push occupancy must leave room for one more outstanding fetch.
  assign can_cont = ~halt &
    ((count + 2'd1 - {1'b0, hs}) < 2'(FETCH_DEPTH));

  always_ff @(posedge clk) begin
    if (!res) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, BUSY: begin
        if (active) begin
          if (done)
            state_nx = (redir_v || !can_cont) ? IDLE : BUSY;
          else
            state_nx = redir_v ? FLUSH : BUSY;
        end
      end
      FLUSH: begin
        if (imem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    issue = (state == IDLE) & ~halt &
            (count < 2'(FETCH_DEPTH));
    imem_req  = res & ((state != IDLE) | issue);
    imem_addr = (state == FLUSH) ? hold_addr : fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
      pc_en     <= 1'b0;
      pc_nxpc   <= RESET_PC;
    end else begin
      pc_en <= hs;
      if (hs) pc_nxpc <= inst_pc;
      if (redir_v) begin
        fetch_pc <= redir_tgt;
        // The in-flight address must stay on imem_addr while flushing.
        if (state != FLUSH) hold_addr <= fetch_pc;
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'(INST_BYTES);
      end
    end
  end

  dark_fetch_buf u_buf (
    .clk      (clk),
    .res      (res),
    .push     (push),
    .push_ent (push_ent),
    .pop      (hs),
    .flush    (redir_v),
    .count    (count),
    .head     (head)
  );

endmodule
